// File: rtl/axi4_usr_sram_bkd_pkg.sv
// Shared definitions for the AXI4 user-side SRAM backend: bus widths, state codes, helpers.
package axi4_usr_sram_bkd_pkg;

   localparam int unsigned AXI4_DATA_WIDTH  = 32;
   localparam int unsigned AXI4_WSTRB_WIDTH = AXI4_DATA_WIDTH / 8;
   localparam int unsigned AXI4_DATA_BLOG   = $clog2(AXI4_WSTRB_WIDTH);

   localparam int unsigned BKD_ST_W = 3;

   localparam logic [BKD_ST_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [BKD_ST_W-1:0] ST_WR_DATA  = 3'd1;
   localparam logic [BKD_ST_W-1:0] ST_WR_RESP  = 3'd2;
   localparam logic [BKD_ST_W-1:0] ST_RD_VALID = 3'd3;
   localparam logic [BKD_ST_W-1:0] ST_INIT     = 3'd4;

   // Write payload presented to the SRAM port
   typedef struct packed {
      logic [AXI4_WSTRB_WIDTH-1:0] bm;
      logic [AXI4_DATA_WIDTH-1:0]  dat;
   } wr_beat_t;

   // SRAM index width for a given depth (at least one bit)
   function automatic int unsigned mem_idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axi4_usr_sram_mem.sv
// Single-port synchronous SRAM with per-byte write mask and a registered, resettable read port.
module axi4_usr_sram_mem
   import axi4_usr_sram_bkd_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = mem_idx_w(DEPTH),
   parameter int unsigned BM_W       = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  we,
   input  logic                  re,
   input  logic [IDX_W-1:0]      idx,
   input  logic [BM_W-1:0]       bm,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Byte-masked write port; array carries no reset so contents survive aresetn
   always_ff @(posedge aclk) begin
      if (we) begin
         for (int b = 0; b < int'(BM_W); b++) begin
            if (bm[b]) mem[idx][b*8 +: 8] <= din[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) dout <= '0;
      else if (re)  dout <= mem[idx];
   end

endmodule

// File: rtl/axi4_usr_sram_bkd.sv
// SRAM backend behind the AXI4 slave FSM user interface: burst counting, handshakes, storage.
// Optional power-up zero sweep of the SRAM is enabled by defining AXI4_USR_SRAM_INIT_EN.
module axi4_usr_sram_bkd
   import axi4_usr_sram_bkd_pkg::*;
#(
   parameter int unsigned USR_ADDR_SIZE  = 64*1024*1024,
   parameter int unsigned USR_ADDR_WIDTH = $clog2(USR_ADDR_SIZE),
   parameter int unsigned MEM_DEPTH      = 1024
) (
   input  logic                                     aclk,
   input  logic                                     aresetn,
   input  logic                                     usr_start_i,
   input  logic                                     usr_rd_i,
   input  logic                                     usr_rdwr_start_i,
   input  logic                                     usr_wen_i,
   input  logic [7:0]                               usr_wlen_i,
   input  logic [7:0]                               usr_rlen_i,
   input  logic [USR_ADDR_WIDTH-AXI4_DATA_BLOG-1:0] usr_addr_i,
   input  logic [AXI4_WSTRB_WIDTH-1:0]              usr_bm_i,
   input  logic [AXI4_DATA_WIDTH-1:0]               usr_dat_i,
   output logic [AXI4_DATA_WIDTH-1:0]               usr_dat_o,
   input  logic                                     usr_bready_i,
   output logic                                     usr_awready_o,
   output logic                                     usr_arready_o,
   output logic                                     usr_wready_o,
   output logic                                     usr_bvalid_o,
   output logic                                     usr_rvalid_o
);

   localparam int unsigned IDX_W  = mem_idx_w(MEM_DEPTH);
   localparam int unsigned UA_W   = USR_ADDR_WIDTH - AXI4_DATA_BLOG;
   localparam int unsigned CNT_W  = 8;

`ifdef AXI4_USR_SRAM_INIT_EN
   localparam logic [BKD_ST_W-1:0] ST_RESET = ST_INIT;
`else
   localparam logic [BKD_ST_W-1:0] ST_RESET = ST_IDLE;
`endif

   logic [BKD_ST_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic                bvalid_q, rvalid_q;

   logic                mem_we_c;
   logic                mem_re_c;
   logic [IDX_W-1:0]    mem_idx_c;
   wr_beat_t            mem_wr_c;

`ifdef AXI4_USR_SRAM_INIT_EN
   logic [IDX_W-1:0]    init_idx_q, init_idx_d;
`endif

   // Address bits above the SRAM index only alias onto the same words
   logic unused_addr_hi;
   if (UA_W > IDX_W) begin : g_addr_hi
      assign unused_addr_hi = ^usr_addr_i[UA_W-1:IDX_W];
   end else begin : g_no_addr_hi
      assign unused_addr_hi = 1'b0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_RESET;
      else          state_q <= state_d;
   end

   // Next-state, burst counter and SRAM port control
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      mem_we_c     = 1'b0;
      mem_re_c     = 1'b0;
      mem_idx_c    = usr_addr_i[IDX_W-1:0];
      mem_wr_c.bm  = usr_bm_i;
      mem_wr_c.dat = usr_dat_i;
`ifdef AXI4_USR_SRAM_INIT_EN
      init_idx_d   = init_idx_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (usr_start_i) begin
               cnt_d = '0;
               if (usr_rd_i) begin
                  len_d    = usr_rlen_i;
                  mem_re_c = 1'b1;
                  state_d  = ST_RD_VALID;
               end else begin
                  len_d    = usr_wlen_i;
                  mem_we_c = usr_rdwr_start_i && usr_wen_i;
                  if (usr_wlen_i == 8'd0) begin
                     state_d = ST_WR_RESP;
                  end else begin
                     cnt_d   = 8'd1;
                     state_d = ST_WR_DATA;
                  end
               end
            end
         end

         ST_WR_DATA: begin
            if (usr_rdwr_start_i && usr_wen_i) begin
               mem_we_c = 1'b1;
               cnt_d    = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = ST_WR_RESP;
            end
         end

         ST_WR_RESP: begin
            if (usr_bready_i) state_d = ST_IDLE;
         end

         // Compare before increment so len=255 yields 256 beats without overflow
         ST_RD_VALID: begin
            if (usr_rdwr_start_i) begin
               if (cnt_q == len_q) begin
                  state_d = ST_IDLE;
               end else begin
                  mem_re_c = 1'b1;
                  cnt_d    = cnt_q + 8'd1;
               end
            end
         end

`ifdef AXI4_USR_SRAM_INIT_EN
         ST_INIT: begin
            mem_we_c     = 1'b1;
            mem_idx_c    = init_idx_q;
            mem_wr_c.bm  = '1;
            mem_wr_c.dat = '0;
            init_idx_d   = init_idx_q + IDX_W'(1);
            if (init_idx_q == IDX_W'(MEM_DEPTH - 1)) state_d = ST_IDLE;
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q    <= '0;
         len_q    <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         bvalid_q <= (state_d == ST_WR_RESP);
         rvalid_q <= (state_d == ST_RD_VALID);
      end
   end

`ifdef AXI4_USR_SRAM_INIT_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) init_idx_q <= '0;
      else          init_idx_q <= init_idx_d;
   end
`endif

   // Accept handshakes decode directly from the state register
   assign usr_awready_o = (state_q == ST_IDLE);
   assign usr_arready_o = (state_q == ST_IDLE);
   assign usr_wready_o  = (state_q == ST_IDLE) || (state_q == ST_WR_DATA);
   assign usr_bvalid_o  = bvalid_q;
   assign usr_rvalid_o  = rvalid_q;

   axi4_usr_sram_mem #(
      .DEPTH      (MEM_DEPTH),
      .DATA_WIDTH (AXI4_DATA_WIDTH),
      .IDX_W      (IDX_W),
      .BM_W       (AXI4_WSTRB_WIDTH)
   ) u_mem (
      .aclk    (aclk),
      .aresetn (aresetn),
      .we      (mem_we_c),
      .re      (mem_re_c),
      .idx     (mem_idx_c),
      .bm      (mem_wr_c.bm),
      .din     (mem_wr_c.dat),
      .dout    (usr_dat_o)
   );

endmodule

// File: tb/tb_axi4_usr_sram_bkd.sv
// Randomized self-checking bench for axi4_usr_sram_bkd against a word-array memory model.
module tb_axi4_usr_sram_bkd;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 24;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          usr_start_i, usr_rd_i, usr_rdwr_start_i, usr_wen_i, usr_bready_i;
   logic [7:0]    usr_wlen_i, usr_rlen_i;
   logic [AW-1:0] usr_addr_i;
   logic [3:0]    usr_bm_i;
   logic [31:0]   usr_dat_i, usr_dat_o;
   logic          usr_awready_o, usr_arready_o, usr_wready_o, usr_bvalid_o, usr_rvalid_o;

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl  [DEPTH];
   logic [31:0] wbuf [256];
   logic [3:0]  wbm  [256];
   logic [31:0] rd_first;

   axi4_usr_sram_bkd dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .usr_start_i      (usr_start_i),
      .usr_rd_i         (usr_rd_i),
      .usr_rdwr_start_i (usr_rdwr_start_i),
      .usr_wen_i        (usr_wen_i),
      .usr_wlen_i       (usr_wlen_i),
      .usr_rlen_i       (usr_rlen_i),
      .usr_addr_i       (usr_addr_i),
      .usr_bm_i         (usr_bm_i),
      .usr_dat_i        (usr_dat_i),
      .usr_dat_o        (usr_dat_o),
      .usr_bready_i     (usr_bready_i),
      .usr_awready_o    (usr_awready_o),
      .usr_arready_o    (usr_arready_o),
      .usr_wready_o     (usr_wready_o),
      .usr_bvalid_o     (usr_bvalid_o),
      .usr_rvalid_o     (usr_rvalid_o)
   );

   always #5 aclk = ~aclk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      usr_start_i = 0; usr_rd_i = 0; usr_rdwr_start_i = 0; usr_wen_i = 0; usr_bready_i = 0;
      usr_wlen_i = 0; usr_rlen_i = 0; usr_addr_i = 0; usr_bm_i = 0; usr_dat_i = 0;
   endtask

   // Memory model: word index is the address modulo the depth, bytes follow the mask
   task automatic mdl_write(input int unsigned a, input logic [31:0] d, input logic [3:0] m);
      int unsigned i = a % DEPTH;
      for (int b = 0; b < 4; b++) if (m[b]) mdl[i][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (usr_awready_o !== 1'b1 && n < 3*DEPTH) begin
         step();
         n++;
      end
   endtask

   // Write burst of len+1 beats; a gap cycle with a non-write beat and a stray start precedes beat gap_at
   task automatic wr_burst(input int unsigned addr, input int len, input int gap_at, input string nm);
      int early = 0;
      int hs_err = 0;
      usr_start_i = 1; usr_rd_i = 0; usr_rdwr_start_i = 1; usr_wen_i = 1;
      usr_wlen_i = 8'(len); usr_addr_i = AW'(addr); usr_bm_i = wbm[0]; usr_dat_i = wbuf[0];
      mdl_write(addr, wbuf[0], wbm[0]);
      step();
      usr_start_i = 0;
      for (int i = 1; i <= len; i++) begin
         if (i == gap_at) begin
            usr_start_i = 1; usr_rdwr_start_i = 1; usr_wen_i = 0;
            usr_addr_i = AW'(addr + i); usr_dat_i = $urandom; usr_bm_i = 4'hF;
            step();
            usr_start_i = 0;
         end
         if (usr_bvalid_o !== 1'b0) early++;
         if (usr_wready_o !== 1'b1 || usr_awready_o !== 1'b0 || usr_arready_o !== 1'b0) hs_err++;
         usr_rdwr_start_i = 1; usr_wen_i = 1;
         usr_addr_i = AW'(addr + i); usr_bm_i = wbm[i]; usr_dat_i = wbuf[i];
         mdl_write(addr + i, wbuf[i], wbm[i]);
         step();
      end
      usr_rdwr_start_i = 0; usr_wen_i = 0;
      tests++;
      if (early != 0) begin
         fails++; $display("FAIL %s_bvalid_early: got %0d early cycles, want 0", nm, early);
      end
      tests++;
      if (hs_err != 0) begin
         fails++; $display("FAIL %s_wdata_readies: got %0d bad cycles, want 0", nm, hs_err);
      end
      tests++;
      if (usr_bvalid_o !== 1'b1 || usr_wready_o !== 1'b0) begin
         fails++; $display("FAIL %s_bvalid: got bvalid=%b wready=%b, want 1 0", nm, usr_bvalid_o, usr_wready_o);
      end
      usr_bready_i = 1;
      step();
      usr_bready_i = 0;
      tests++;
      if (usr_bvalid_o !== 1'b0 || usr_awready_o !== 1'b1) begin
         fails++; $display("FAIL %s_bresp_done: got bvalid=%b awready=%b, want 0 1", nm, usr_bvalid_o, usr_awready_o);
      end
   endtask

   // Read burst with a consumed beat every cycle; data compared against the model
   task automatic rd_burst(input int unsigned addr, input int len, input string nm);
      int verr = 0;
      int derr = 0;
      logic [31:0] fa = 0, fe = 0;
      usr_start_i = 1; usr_rd_i = 1; usr_rlen_i = 8'(len); usr_addr_i = AW'(addr);
      step();
      usr_start_i = 0; usr_rd_i = 0;
      rd_first = usr_dat_o;
      for (int i = 0; i <= len; i++) begin
         if (usr_rvalid_o !== 1'b1) verr++;
         if (usr_dat_o !== mdl[(addr + i) % DEPTH]) begin
            if (derr == 0) begin fa = usr_dat_o; fe = mdl[(addr + i) % DEPTH]; end
            derr++;
         end
         usr_rdwr_start_i = 1; usr_addr_i = AW'(addr + i + 1);
         step();
      end
      usr_rdwr_start_i = 0;
      tests++;
      if (verr != 0) begin
         fails++; $display("FAIL %s_rvalid_held: got %0d cycles without rvalid, want 0", nm, verr);
      end
      tests++;
      if (derr != 0) begin
         fails++; $display("FAIL %s_rdata: %0d bad beats, first got %h want %h", nm, derr, fa, fe);
      end
      tests++;
      if (usr_rvalid_o !== 1'b0 || usr_arready_o !== 1'b1) begin
         fails++; $display("FAIL %s_rd_done: got rvalid=%b arready=%b, want 0 1", nm, usr_rvalid_o, usr_arready_o);
      end
   endtask

   task automatic test_reset();
      int n;
      idle_inputs();
      aresetn = 0;
      repeat (3) step();
      tests++;
      if (usr_bvalid_o !== 1'b0 || usr_rvalid_o !== 1'b0 || usr_dat_o !== 32'h0) begin
         fails++; $display("FAIL reset_values: got bvalid=%b rvalid=%b dat=%h, want 0 0 0", usr_bvalid_o, usr_rvalid_o, usr_dat_o);
      end
      @(negedge aclk);
      aresetn = 1;
      step();
      wait_ready(n);
`ifdef AXI4_USR_SRAM_INIT_EN
      tests++;
      if (n < int'(DEPTH) - 2 || n > int'(DEPTH)) begin
         fails++; $display("FAIL init_sweep_len: got %0d cycles not ready, want about %0d", n, DEPTH - 1);
      end
`else
      tests++;
      if (n != 0) begin
         fails++; $display("FAIL reset_idle: got %0d cycles not ready, want 0", n);
      end
`endif
      tests++;
      if (usr_awready_o !== 1'b1 || usr_arready_o !== 1'b1 || usr_wready_o !== 1'b1) begin
         fails++; $display("FAIL reset_readies: got aw=%b ar=%b w=%b, want 1 1 1", usr_awready_o, usr_arready_o, usr_wready_o);
      end
      tests++;
      if (usr_bvalid_o !== 1'b0 || usr_rvalid_o !== 1'b0) begin
         fails++; $display("FAIL reset_valids: got bvalid=%b rvalid=%b, want 0 0", usr_bvalid_o, usr_rvalid_o);
      end
   endtask

   task automatic test_single();
      wbuf[0] = 32'hDEADBEEF; wbm[0] = 4'hF;
      wr_burst(32'h10, 0, -1, "single_wr");
      rd_burst(32'h10, 0, "single_rd");
      tests++;
      if (rd_first !== 32'hDEADBEEF) begin
         fails++; $display("FAIL single_const: got %h want deadbeef", rd_first);
      end
   endtask

   task automatic test_incr();
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); wbm[i] = 4'hF; end
      wr_burst(32'h20, 3, 2, "incr_wr");
      rd_burst(32'h20, 3, "incr_rd");
   endtask

   task automatic test_bytemask();
      wbuf[0] = 32'hFFFFFFFF; wbm[0] = 4'hF;
      wr_burst(32'h30, 0, -1, "bm_full");
      wbuf[0] = 32'h00000000; wbm[0] = 4'b0101;
      wr_burst(32'h30, 0, -1, "bm_part");
      rd_burst(32'h30, 0, "bm_rd");
      tests++;
      if (rd_first !== 32'hFF00FF00) begin
         fails++; $display("FAIL bm_const: got %h want ff00ff00", rd_first);
      end
   endtask

   task automatic test_idle_ignore();
      usr_rdwr_start_i = 1; usr_wen_i = 1; usr_addr_i = AW'(32'h10);
      usr_dat_i = 32'h12345678; usr_bm_i = 4'hF;
      step();
      idle_inputs();
      tests++;
      if (usr_bvalid_o !== 1'b0 || usr_rvalid_o !== 1'b0 || usr_awready_o !== 1'b1) begin
         fails++; $display("FAIL idle_ignore_state: got bvalid=%b rvalid=%b awready=%b, want 0 0 1", usr_bvalid_o, usr_rvalid_o, usr_awready_o);
      end
      rd_burst(32'h10, 0, "idle_ignore_rd");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int len = int'($urandom_range(0, 15));
         int unsigned a = $urandom_range(32'h100, 32'h3FF);
         int gap = int'($urandom_range(1, 16));
         for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; wbm[i] = 4'hF; end
         wr_burst(a, len, gap, "rnd_fill");
         for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; wbm[i] = 4'($urandom); end
         wr_burst(a, len, gap, "rnd_mask");
         rd_burst(a, len, "rnd_rd");
      end
   endtask

   task automatic test_long();
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; wbm[i] = 4'hF; end
      wr_burst(32'h200, 255, -1, "long_wr");
      rd_burst(32'h200, 255, "long_rd");
   endtask

   task automatic test_alias();
      wbuf[0] = 32'hA5A50001; wbm[0] = 4'hF;
      wr_burst(32'h10 + DEPTH, 0, -1, "alias_wr");
      rd_burst(32'h10, 0, "alias_rd");
      tests++;
      if (rd_first !== 32'hA5A50001) begin
         fails++; $display("FAIL alias_const: got %h want a5a50001", rd_first);
      end
      rd_burst(32'h10 + 2*DEPTH, 0, "alias_rd2");
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE0000 + 32'(i); wbm[i] = 4'hF; end
      wr_burst(32'h40, 3, -1, "rstmid_wr");
      usr_start_i = 1; usr_rd_i = 1; usr_rlen_i = 8'd3; usr_addr_i = AW'(32'h40);
      step();
      usr_start_i = 0; usr_rd_i = 0;
      usr_rdwr_start_i = 1; usr_addr_i = AW'(32'h41);
      step();
      usr_rdwr_start_i = 0;
      tests++;
      if (usr_rvalid_o !== 1'b1 || usr_dat_o !== 32'hC0DE0001) begin
         fails++; $display("FAIL rstmid_beat2: got rvalid=%b dat=%h, want 1 c0de0001", usr_rvalid_o, usr_dat_o);
      end
      #2 aresetn = 0;
      #1;
      tests++;
      if (usr_rvalid_o !== 1'b0 || usr_dat_o !== 32'h0 || usr_bvalid_o !== 1'b0) begin
         fails++; $display("FAIL rstmid_async: got rvalid=%b bvalid=%b dat=%h, want 0 0 0", usr_rvalid_o, usr_bvalid_o, usr_dat_o);
      end
      step();
      @(negedge aclk);
      aresetn = 1;
      step();
      wait_ready(n);
      tests++;
      if (usr_awready_o !== 1'b1 || usr_arready_o !== 1'b1 || usr_wready_o !== 1'b1) begin
         fails++; $display("FAIL rstmid_readies: got aw=%b ar=%b w=%b, want 1 1 1", usr_awready_o, usr_arready_o, usr_wready_o);
      end
`ifdef AXI4_USR_SRAM_INIT_EN
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
      rd_burst(32'h3F0, 3, "init_unwritten");
`else
      rd_burst(32'h40, 3, "rstmid_retained");
      rd_burst(32'h20, 3, "rstmid_retained2");
`endif
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
      test_reset();
`ifdef AXI4_USR_SRAM_INIT_EN
      rd_burst(32'h3F0, 3, "init_zero");
`endif
      test_single();
      test_incr();
      test_bytemask();
      test_idle_ignore();
      test_random();
      test_long();
      test_alias();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi4_usr_sram_bkd.md
Name: axi4_usr_sram_bkd

Overview:
- Memory backend that sits directly downstream of the AXI4 slave FSM's user interface.
- Consumes the per-transaction pulse (usr_start), the per-beat pulse (usr_rdwr_start), word address, byte mask and write data.
- Stores data in an internal byte-maskable synchronous SRAM.
- Returns read data and the awready/wready/bvalid/arready/rvalid handshakes that the FSM forwards onto AXI.

Parameters:
USR_ADDR_SIZE, 64*1024*1024, user address space in bytes; must match the FSM instance.
USR_ADDR_WIDTH, $clog2(USR_ADDR_SIZE), derived; not overridden.
MEM_DEPTH, 1024, SRAM depth in AXI4_DATA_WIDTH words; power of two.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
usr_start_i  in  1  transaction-accept pulse
usr_rd_i  in  1  qualifies usr_start_i as a read; top level ties it to arvalid&&arready
usr_rdwr_start_i  in  1  beat pulse: write beat accepted, or read beat consumed
usr_wen_i  in  1  beat is a write
usr_wlen_i  in  8  write burst length (AXI len, beats-1); sampled on write start
usr_rlen_i  in  8  read burst length (AXI arlen); sampled on read start
usr_addr_i  in  USR_ADDR_WIDTH-AXI4_DATA_BLOG  word address
usr_bm_i  in  AXI4_WSTRB_WIDTH  byte mask
usr_dat_i  in  AXI4_DATA_WIDTH  write data
usr_dat_o  out  AXI4_DATA_WIDTH  read data (registered)
usr_bready_i  in  1  AXI bready
usr_awready_o, usr_arready_o, usr_wready_o  out  1  each  accept handshakes
usr_bvalid_o, usr_rvalid_o  out  1  each  response valids

Behaviour:
- Interface: reset is aresetn, asynchronous, active-low; clock is aclk.
- Reset values: state IDLE, all valids 0, usr_dat_o 0, beat counter 0, latched length 0.
  - awready/arready/wready are combinational from state, so they read 1 in IDLE after reset.
- SRAM index: usr_addr_i[$clog2(MEM_DEPTH)-1:0]. Upper bits are ignored, so addresses alias (wrap).
- SRAM timing:
  - Writes commit at the clock edge of the beat, honouring usr_bm_i per byte.
  - Reads register mem[index] into usr_dat_o at the issue edge, so data is valid the next cycle (latency 1).
- States:
  - IDLE: awready=arready=wready=1.
    - usr_start_i&&usr_rd_i: latch rlen, cnt<=0, issue read at usr_addr_i, go RD_VALID.
    - usr_start_i&&!usr_rd_i: latch wlen, cnt<=0.
      - Same-cycle usr_rdwr_start_i&&usr_wen_i: write the beat.
      - Then, if wlen==0, go WR_RESP; else cnt<=1 and go WR_DATA.
  - WR_DATA: wready=1, all others 0.
    - Each usr_rdwr_start_i&&usr_wen_i writes one beat and increments cnt.
    - The beat on which cnt==len goes to WR_RESP.
  - WR_RESP: bvalid=1. usr_bready_i goes to IDLE.
  - RD_VALID: rvalid=1.
    - On usr_rdwr_start_i with cnt==len: go IDLE; rvalid falls next cycle.
    - On usr_rdwr_start_i with cnt!=len: issue read at usr_addr_i, cnt++, stay; rvalid stays high (back-to-back, one beat/cycle).
- Counter: 8-bit. len=255 gives 256 beats with no overflow, because the compare fires before the increment.
- Ignored inputs:
  - usr_start_i outside IDLE.
  - usr_rdwr_start_i with usr_wen_i=0 in WR_DATA.
  - usr_rdwr_start_i in IDLE without usr_start_i.
- Reset mid-burst: immediate return to reset values. SRAM contents are retained (see optional feature).
- No error responses; bresp/rresp stay OKAY in the FSM.

Optional Feature:
- Macro: AXI4_USR_SRAM_INIT_EN.
- Defined:
  - After reset, state INIT sweeps the SRAM, writing 0 to one word per cycle for MEM_DEPTH cycles.
  - All readies and valids are 0 during INIT; then the block enters IDLE.
  - Reads of never-written words return 0.
- Undefined: no INIT state; IDLE immediately after reset; contents are undefined until written.

Decomposition:
- The shared define header (alongside axi4_define.sv) carries:
  - the backend state enum (IDLE, WR_DATA, WR_RESP, RD_VALID, INIT);
  - the MEM index width helper constant.
- Sub-module axi4_usr_sram_mem: single-port synchronous RAM with byte mask, registered read, parameter DEPTH and DATA_WIDTH.
- The FSM, counter and handshakes stay in axi4_usr_sram_bkd.

Test Plan:
- Single write then read:
  - Write start with beat, wlen=0, addr=0x10, data=0xDEADBEEF, bm all-ones -> bvalid next cycle.
  - bready -> IDLE.
  - Read start rlen=0 at 0x10 -> rvalid next cycle, usr_dat_o=0xDEADBEEF.
  - Handshake -> rvalid=0.
- INCR write of 4 beats:
  - wlen=3, addrs 0x20..0x23, data 1..4, with a one-cycle gap before beat 3 -> bvalid only after the 4th beat.
  - Read back rlen=3 with rready every cycle -> rvalid held 4 consecutive cycles, data 1,2,3,4.
- Byte mask: write 0xFFFFFFFF, then 0x00000000 with bm=0b0101 -> read 0xFF00FF00.
- Boundaries:
  - wlen=255 -> exactly 256 beats before bvalid.
  - Address 0x10+MEM_DEPTH aliases to 0x10.
- Reset mid-burst:
  - Assert aresetn=0 during RD_VALID beat 2 of 4 -> rvalid=0 and usr_dat_o=0 asynchronously.
  - After release: IDLE with readies=1, and earlier-written data intact.
- With AXI4_USR_SRAM_INIT_EN:
  - Readies stay 0 for MEM_DEPTH cycles after reset.
  - A read of any unwritten address returns 0.
